// File: rtl/keyboard_serial_tx_if.sv
// Key-event valid/ready port for the CH446Q-style serial transmitter.
// Carries {ay, ax, state} from the key-mapping logic.
interface keyboard_serial_tx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_ay;
  logic [3:0] ev_ax;
  logic       ev_state;

  modport master (
    output ev_valid, ev_ay, ev_ax, ev_state,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_ay, ev_ax, ev_state,
    output ev_ready
  );
endinterface

// File: rtl/keyboard_serial_tx.sv
// CH446Q-style DAT/SK/STB frame transmitter with an event FIFO.
// Optional KEYBOARD_TX_SHADOW_EN drops events matching the receiver state.
module keyboard_serial_tx #(
  parameter int DIV        = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_in,
  keyboard_serial_tx_if.slave         ev,
  output logic                        DAT,
  output logic                        SK,
  output logic                        STB,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, BIT_LO, BIT_HI, SETUP, STROBE, HOLD
  } state_t;

  state_t          st_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [6:0]      word_q;
  logic            sv_q;
  logic            dat_q, sk_q, stb_q, busy_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic            rdy_q;
  logic            push, pop, skip, last;
  logic [7:0]      head;

  assign push = ev.ev_valid & rdy_q;
  assign pop  = (st_q == IDLE) && (lvl_q != '0);
  assign head = mem_q[rd_q];
  assign last = (cnt_q == CW'(DIV - 1));

  assign lvl_d = lvl_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {ev.ev_ay, ev.ev_ax, ev.ev_state};
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_d;
      rdy_q <= (lvl_d != LW'(FIFO_DEPTH));
    end
  end

`ifdef KEYBOARD_TX_SHADOW_EN
  logic [63:0] sh_q;
  logic [2:0]  shx_q;
  logic        trk, shb;
  logic [1:0]  hx, wx;

  assign hx = 2'(head[7:5] - 3'd5);
  assign wx = 2'(word_q[6:4] - 3'd5);

  always_comb begin
    trk = 1'b0;
    shb = 1'b0;
    unique case (1'b1)
      !head[4]: begin
        trk = 1'b1;
        shb = sh_q[{head[7:5], head[3:1]}];
      end
      (head[4:1] == 4'd8) && (head[7:5] >= 3'd5): begin
        trk = 1'b1;
        shb = shx_q[hx];
      end
      default: ;
    endcase
  end

  assign skip = trk && (shb == head[0]);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      word_q <= '0;
      sv_q   <= 1'b0;
      dat_q  <= 1'b0;
      sk_q   <= 1'b0;
      stb_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef KEYBOARD_TX_SHADOW_EN
      sh_q   <= '1;
      shx_q  <= '1;
`endif
    end else if (st_q != IDLE && !last) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
      unique case (st_q)
        IDLE: if (pop && !skip) begin
          word_q <= head[7:1];
          sv_q   <= head[0];
          bit_q  <= 3'd6;
          dat_q  <= head[7];
          sk_q   <= 1'b0;
          busy_q <= 1'b1;
          st_q   <= BIT_LO;
        end
        BIT_LO: begin
          sk_q <= 1'b1;
          st_q <= BIT_HI;
        end
        BIT_HI: begin
          sk_q <= 1'b0;
          if (bit_q == 3'd0) begin
            dat_q <= sv_q;
            st_q  <= SETUP;
          end else begin
            bit_q <= bit_q - 3'd1;
            dat_q <= word_q[bit_q - 3'd1];
            st_q  <= BIT_LO;
          end
        end
        SETUP: begin
          stb_q <= 1'b1;
          st_q  <= STROBE;
`ifdef KEYBOARD_TX_SHADOW_EN
          // Mirror what the receiver latches on this strobe.
          if (!word_q[3])
            sh_q[{word_q[6:4], word_q[2:0]}] <= sv_q;
          else if (word_q[3:0] == 4'd8 && word_q[6:4] >= 3'd5)
            shx_q[wx] <= sv_q;
`endif
        end
        STROBE: begin
          stb_q <= 1'b0;
          st_q  <= HOLD;
        end
        HOLD: begin
          dat_q  <= 1'b0;
          busy_q <= 1'b0;
          st_q   <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign ev.ev_ready = rdy_q;
  assign DAT         = dat_q;
  assign SK          = sk_q;
  assign STB         = stb_q;
  assign busy        = busy_q;
  assign fifo_level  = lvl_q;

endmodule

// File: tb/tb_keyboard_serial_tx.sv
// Directed + random bench for keyboard_serial_tx (DIV=2, depth 8).
// Frames are decoded from the pins and matched against a queue model.
module tb_keyboard_serial_tx;
  localparam int DIV   = 2;
  localparam int DEPTH = 8;
  localparam int LIM   = 4000;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       DAT, SK, STB, busy;
  logic [3:0] fifo_level;

  keyboard_serial_tx_if evif ();

  keyboard_serial_tx #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .ev         (evif.slave),
    .DAT        (DAT),
    .SK         (SK),
    .STB        (STB),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         skn_q[$];
  int         stbn_q[$];
  int         blen_q[$];
  logic       sh [8][16];

  logic       psk, pstb, pb;
  logic [6:0] sreg;
  int         skn, stbn, blen;

  always @(negedge clk) begin
    if (!rst_in) begin
      psk <= 1'b0; pstb <= 1'b0; pb <= 1'b0;
      sreg <= '0; skn <= 0; stbn <= 0; blen <= 0;
    end else begin
      psk <= SK; pstb <= STB; pb <= busy;
      if (busy) blen <= blen + 1;
      else if (pb) begin blen_q.push_back(blen); blen <= 0; end
      if (SK && !psk) begin
        sreg <= {sreg[5:0], DAT};
        skn  <= skn + 1;
      end
      if (STB && !pstb) begin
        obs_q.push_back({sreg, DAT});
        skn_q.push_back(skn);
        skn <= 0;
      end
      if (STB) stbn <= stbn + 1;
      else if (pstb) begin stbn_q.push_back(stbn); stbn <= 0; end
    end
  end

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic sh_reset();
    for (int a = 0; a < 8; a++)
      for (int x = 0; x < 16; x++) sh[a][x] = 1'b1;
  endtask

  // Receiver-state model: only keys the receiver tracks can be suppressed.
  task automatic model_push(logic [2:0] ay, logic [3:0] ax, logic s);
`ifdef KEYBOARD_TX_SHADOW_EN
    bit trk;
    trk = (ax < 8) || (ax == 8 && ay >= 5);
    if (!trk || sh[ay][ax] != s) exp_q.push_back({ay, ax, s});
    if (trk) sh[ay][ax] = s;
`else
    exp_q.push_back({ay, ax, s});
`endif
  endtask

  task automatic drive(logic [2:0] ay, logic [3:0] ax, logic s);
    evif.ev_valid = 1'b1;
    evif.ev_ay    = ay;
    evif.ev_ax    = ax;
    evif.ev_state = s;
  endtask

  task automatic send(logic [2:0] ay, logic [3:0] ax, logic s);
    int n = 0;
    @(negedge clk);
    drive(ay, ax, s);
    while (!evif.ev_ready && n < LIM) begin @(negedge clk); n++; end
    chk("send_wait", 32'(n < LIM), 1);
    @(posedge clk);
    #1 evif.ev_valid = 1'b0;
    model_push(ay, ax, s);
  endtask

  task automatic drain(string tag);
    int n = 0;
    while (n < LIM && (busy || fifo_level != 0 ||
           obs_q.size() < exp_q.size())) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_nframes"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      chk({tag, "_frame"}, obs_q.pop_front(), exp_q.pop_front());
      chk({tag, "_skn"},  skn_q.size()  ? skn_q.pop_front()  : -1, 7);
      chk({tag, "_stb"},  stbn_q.size() ? stbn_q.pop_front() : -1, DIV);
      chk({tag, "_busy"}, blen_q.size() ? blen_q.pop_front() : -1, 17*DIV);
    end
    exp_q.delete(); obs_q.delete();
    skn_q.delete(); stbn_q.delete(); blen_q.delete();
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ev [12];
    int k, c, full_at, n, base;
    bit ret_done;

    sh_reset();
    evif.ev_valid = 1'b0;
    evif.ev_ay = '0; evif.ev_ax = '0; evif.ev_state = 1'b0;
    rst_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dat", DAT, 0);
    chk("rst_sk", SK, 0);
    chk("rst_stb", STB, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lvl", fifo_level, 0);
    chk("rst_rdy", evif.ev_ready, 0);
    rst_in = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", evif.ev_ready, 1);

    send(3'd2, 4'd4, 1'b0);
    drain("t1");

    send(3'd6, 4'd8, 1'b0);
    send(3'd6, 4'd8, 1'b1);
    drain("t2");

    for (int i = 0; i < 12; i++)
      ev[i] = {3'(i % 5), 4'(9 + i % 7), 1'($urandom_range(0, 1))};
    k = 0; c = 0; full_at = -1; ret_done = 0;
    @(negedge clk);
    while (k < 12 && c < LIM) begin
      drive(ev[k][7:5], ev[k][4:1], ev[k][0]);
      if (evif.ev_ready) begin
        if (full_at >= 0 && !ret_done) begin
          chk("t3_ret_lvl", fifo_level, DEPTH - 1);
          ret_done = 1;
        end
        @(posedge clk);
        model_push(ev[k][7:5], ev[k][4:1], ev[k][0]);
        k++;
      end else if (full_at < 0) begin
        full_at = k;
        chk("t3_full_lvl", fifo_level, DEPTH);
      end
      @(negedge clk); c++;
    end
    evif.ev_valid = 1'b0;
    chk("t3_accepted", full_at, DEPTH + 1);
    chk("t3_ret_seen", ret_done, 1);
    drain("t3");

    for (int i = 0; i < 40; i++) begin
      logic [3:0] ax;
      ax = $urandom_range(0, 1) ? 4'($urandom_range(0, 9))
                                : 4'($urandom_range(10, 15));
      send(3'($urandom_range(0, 7)), ax, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("rnd");

    send(3'd1, 4'd9, 1'b0);
    send(3'd1, 4'd10, 1'b1);
    send(3'd2, 4'd11, 1'b0);
    send(3'd3, 4'd12, 1'b1);
    n = 0;
    while (n < LIM && !(busy == 1'b0 && fifo_level == 3)) begin
      @(negedge clk); n++;
    end
    chk("t6_pre_lvl", fifo_level, 3);
    drive(3'd4, 4'd13, 1'b0);
    @(posedge clk);
    #1 evif.ev_valid = 1'b0;
    model_push(3'd4, 4'd13, 1'b0);
    chk("t6_lvl", fifo_level, 3);
    chk("t6_busy", busy, 1);
    drain("t6");

    send(3'd3, 4'd10, 1'b1);
    send(3'd2, 4'd9, 1'b0);
    n = 0;
    @(negedge clk);
    while (n < LIM && !SK) begin @(negedge clk); n++; end
    chk("t4_in_bithi", SK, 1);
    #2 rst_in = 1'b0;
    #1;
    chk("t4_sk", SK, 0);
    chk("t4_dat", DAT, 0);
    chk("t4_stb", STB, 0);
    chk("t4_lvl", fifo_level, 0);
    chk("t4_busy", busy, 0);
    exp_q.delete(); obs_q.delete();
    skn_q.delete(); stbn_q.delete(); blen_q.delete();
    sh_reset();
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
    repeat (40) @(negedge clk);
    chk("t4_no_stb", obs_q.size(), 0);
    send(3'd5, 4'd8, 1'b0);
    drain("t4");

    send(3'd0, 4'd0, 1'b1);
    repeat (50) @(negedge clk);
    chk("t5_first", obs_q.size(), exp_q.size());
    base = exp_q.size();
    send(3'd0, 4'd0, 1'b0);
    send(3'd0, 4'd0, 1'b0);
    send(3'd0, 4'd0, 1'b1);
`ifdef KEYBOARD_TX_SHADOW_EN
    chk("t5_model", exp_q.size() - base, 2);
`endif
    drain("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
